alert_arbiter: RTL and testbench
================================

// Module: alert_arbiter
// PURPOSE
//  Shares the single piezo and the RGB LED among alert sources (timer ring, alarm, hourly chime, key beep).
//  Grants exactly one requester at a time using fixed priority, a minimum hold time and a silent hand-over gap.
//  Generates the granted source's on/off tone pattern and drives its colour.
//  Sits between the timer/alarm controllers and the top-level piezo/RGB pins.
// PARAMETERS
//  N_REQ        4    number of requesters; bit index = priority, highest index wins
//  MIN_HOLD_MS  200  minimum grant duration in clk_1k cycles
//  GAP_MS       50   silent cycles between consecutive grants
//  SLOW_ON_MS   500  on-time of slow pattern within its 1000-cycle period
//  FAST_HALF_MS 100  on/off half-period of fast pattern
// PORTS
//  clk_1k      in   1        1 kHz system clock
//  rst_n       in   1        asynchronous active-low reset
//  mute        in   1        forces piezo_out=0; arbitration and LED unaffected
//  req         in   N_REQ    level requests
//  pattern     in   2*N_REQ  per-requester code: 0 continuous, 1 slow, 2 fast, 3 LED-only
//  rgb_req     in   3*N_REQ  per-requester colour {r,g,b}
//  grant       out  N_REQ    one-hot owner; 0 when idle or in gap
//  busy        out  1        1 in ACTIVE or GAP
//  piezo_out   out  1        500 Hz square wave, gated by pattern
//  rgb_out     out  3        owner's rgb_req; 0 when no owner
//  preempt_cnt out  8        saturating count of preemptions
// BEHAVIOUR
//  Reset: all outputs, counters and state are 0, state=IDLE; asserted asynchronously, including mid-grant.
//  All outputs are registered; a request is first visible on grant 1 cycle after it is sampled.
//  State IDLE:
//   any req -> ACTIVE; owner = highest set bit; hold_cnt=0, pat_cnt=0.
//  State ACTIVE:
//   hold_cnt increments, saturating at MIN_HOLD_MS.
//   pat_cnt wraps 0..999.
//   Owner's req is ignored until hold_cnt==MIN_HOLD_MS. A 1-cycle pulse therefore yields exactly MIN_HOLD_MS grant cycles.
//   Once hold is met, owner req low -> GAP (release).
//   Once hold is met, owner req high and a higher-index req high -> GAP (preempt); preempt_cnt++, saturating at 255.
//   Release and higher req in the same cycle are treated as a release; no count.
//   Lower-index requests never disturb the owner.
//  State GAP:
//   grant=0, piezo_out=0, rgb_out=0; gap_cnt runs GAP_MS cycles.
//   Then: any req -> ACTIVE with re-arbitration (the previous owner is eligible); else -> IDLE.
//  Tone:
//   tone_en is derived from pat_cnt: continuous=1; slow=(pat_cnt<SLOW_ON_MS); fast=((pat_cnt mod 2*FAST_HALF_MS)<FAST_HALF_MS); LED-only=0.
//   piezo flop toggles every cycle while ACTIVE && tone_en && !mute; otherwise it is held at 0.
//   The first toggle to 1 occurs on the grant's first cycle.
//  pattern/rgb_req are muxed from the current owner every cycle, so changes take effect with 1-cycle latency.
//  grant is never non-zero in two consecutive grants without >=GAP_MS zero cycles between them.
// STRUCTURE
//  Shared package alert_pkg: state encodings (IDLE/ACTIVE/GAP), pattern codes PAT_CONT/PAT_SLOW/PAT_FAST/PAT_LED, colour constants.
//  Sub-module alert_tone_gen: pat_cnt, fast-phase counter and piezo toggle flop.
//  Its inputs are active, pattern code and mute; its output is piezo_out.
//  The top level holds the FSM, priority encoder, hold/gap counters and preempt_cnt.
// TESTING
//  1. req=0001, pattern=0 at t0, release at t0+300 -> grant=0001 at t0+1; piezo toggles each cycle;
//     grant=0 at t0+301; busy drops at t0+351.
//  2. req[0] 1-cycle pulse -> grant=0001 for exactly 200 cycles, then 50 gap cycles, then IDLE.
//  3. req[0] held; req[3] rises at grant cycle 300 -> 50 gap cycles, grant=1000, preempt_cnt=1.
//  4. req[3] rises at grant cycle 50 of req[0] -> switch waits until hold=200; req[1] rising mid-grant is ignored.
//  5. pattern=1 continuous request -> piezo active cycles 0-499, silent 500-999, repeats;
//     mute=1 -> piezo_out=0 while grant and rgb_out remain unchanged.
//  6. rst_n low during ACTIVE -> grant, piezo_out, rgb_out and preempt_cnt are 0 immediately;
//     after release, a pending req is granted 1 cycle later.

Source files
------------

// File: rtl/alert_pkg.sv
// Shared types and constants for the alert arbiter.
// FSM encodings, tone pattern codes, colour constants and timing.
package alert_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam logic [1:0] PAT_CONT = 2'd0;
  localparam logic [1:0] PAT_SLOW = 2'd1;
  localparam logic [1:0] PAT_FAST = 2'd2;
  localparam logic [1:0] PAT_LED  = 2'd3;

  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  localparam int PAT_PERIOD = 1000;

endpackage

// File: rtl/alert_if.sv
// Request/grant bundle between alert sources and the arbiter.
// master: sources drive req/pattern/rgb_req/mute; slave: arbiter.
interface alert_if #(
  parameter int N_REQ = 4
);
  logic               mute;
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] pattern;
  logic [3*N_REQ-1:0] rgb_req;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               piezo_out;
  logic [2:0]         rgb_out;
  logic [7:0]         preempt_cnt;

  modport master (
    output mute, req, pattern, rgb_req,
    input  grant, busy, piezo_out,
    input  rgb_out, preempt_cnt
  );

  modport slave (
    input  mute, req, pattern, rgb_req,
    output grant, busy, piezo_out,
    output rgb_out, preempt_cnt
  );
endinterface

// File: rtl/alert_tone_gen.sv
// Piezo pattern generator: pattern counter, fast phase, toggle flop.
// Ports: clk_1k, rst_n, active (next-cycle), pat, mute -> piezo_out.
module alert_tone_gen
  import alert_pkg::*;
#(
  parameter int SLOW_ON_MS   = 500,
  parameter int FAST_HALF_MS = 100
) (
  input  logic       clk_1k,
  input  logic       rst_n,
  input  logic       active,
  input  logic [1:0] pat,
  input  logic       mute,
  output logic       piezo_out
);

  localparam int FW = $clog2(2 * FAST_HALF_MS);

  logic          act_q;
  logic [9:0]    pat_cnt;
  logic [9:0]    pat_nxt;
  logic [FW-1:0] fast_cnt;
  logic [FW-1:0] fast_nxt;
  logic          tone_en;
  logic          piezo_d;

  // Counters restart at 0 on the first cycle of every grant,
  // so the registered outputs line up with the grant's cycle index.
  always_comb begin
    pat_nxt  = '0;
    fast_nxt = '0;
    if (active && act_q) begin
      if (pat_cnt == 10'(PAT_PERIOD - 1))
        pat_nxt = '0;
      else
        pat_nxt = pat_cnt + 10'd1;
      if (fast_cnt == FW'(2 * FAST_HALF_MS - 1))
        fast_nxt = '0;
      else
        fast_nxt = fast_cnt + FW'(1);
    end
  end

  always_comb begin
    tone_en = 1'b0;
    unique case (1'b1)
      (pat == PAT_CONT): tone_en = 1'b1;
      (pat == PAT_SLOW):
        tone_en = (pat_nxt < 10'(SLOW_ON_MS));
      (pat == PAT_FAST):
        tone_en = (fast_nxt < FW'(FAST_HALF_MS));
      default: tone_en = 1'b0;
    endcase
  end

  assign piezo_d = (active && tone_en && !mute)
                 ? ~piezo_out : 1'b0;

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      act_q     <= 1'b0;
      pat_cnt   <= '0;
      fast_cnt  <= '0;
      piezo_out <= 1'b0;
    end else begin
      act_q     <= active;
      pat_cnt   <= pat_nxt;
      fast_cnt  <= fast_nxt;
      piezo_out <= piezo_d;
    end
  end

endmodule

// File: rtl/alert_arbiter.sv
// Fixed-priority piezo/RGB arbiter with minimum hold and silent gap.
// Ports: clk_1k, rst_n, bus (alert_if.slave: req/pattern/rgb in, grant/busy/piezo/rgb/preempt out).
module alert_arbiter
  import alert_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MIN_HOLD_MS  = 200,
  parameter int GAP_MS       = 50,
  parameter int SLOW_ON_MS   = 500,
  parameter int FAST_HALF_MS = 100
) (
  input  logic clk_1k,
  input  logic rst_n,
  alert_if.slave bus
);

  localparam int HW = $clog2(MIN_HOLD_MS + 1);
  localparam int GW = $clog2(GAP_MS + 1);

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [N_REQ-1:0] owner;
  logic [N_REQ-1:0] owner_d;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hold_d;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_d;
  logic [7:0]       pre_d;

  logic [N_REQ-1:0] hi;
  logic [N_REQ-1:0] upto;
  logic             owner_req;
  logic             higher_req;
  logic             hold_met;
  logic             act_d;
  logic [2:0]       rgb_sel;
  logic [1:0]       pat_sel;

  always_comb begin
    hi = '0;
    for (int i = 0; i < N_REQ; i++)
      if (bus.req[i]) hi = N_REQ'(1) << i;
  end

  // Bits at or below the owner; everything else outranks it.
  assign upto       = (owner << 1) - N_REQ'(1);
  assign owner_req  = |(bus.req & owner);
  assign higher_req = |(bus.req & ~upto);
  // Counting the entry cycle as hold 0 gives exactly
  // MIN_HOLD_MS granted cycles before a release can land.
  assign hold_met   = (hold_cnt >= HW'(MIN_HOLD_MS - 1));

  always_comb begin
    state_d = state;
    owner_d = owner;
    hold_d  = hold_cnt;
    gap_d   = gap_cnt;
    pre_d   = bus.preempt_cnt;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (|bus.req) begin
          state_d = ST_ACTIVE;
          owner_d = hi;
          hold_d  = '0;
        end
      end
      (state == ST_ACTIVE): begin
        if (hold_cnt < HW'(MIN_HOLD_MS))
          hold_d = hold_cnt + HW'(1);
        if (hold_met && !owner_req) begin
          state_d = ST_GAP;
          owner_d = '0;
          gap_d   = '0;
        end else if (hold_met && higher_req) begin
          state_d = ST_GAP;
          owner_d = '0;
          gap_d   = '0;
          if (bus.preempt_cnt != 8'hFF)
            pre_d = bus.preempt_cnt + 8'd1;
        end
      end
      (state == ST_GAP): begin
        if (gap_cnt == GW'(GAP_MS - 1)) begin
          if (|bus.req) begin
            state_d = ST_ACTIVE;
            owner_d = hi;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            owner_d = '0;
          end
        end else begin
          gap_d = gap_cnt + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    endcase
  end

  assign act_d = (state_d == ST_ACTIVE);

  always_comb begin
    rgb_sel = RGB_OFF;
    pat_sel = PAT_CONT;
    for (int i = 0; i < N_REQ; i++)
      if (owner_d[i]) begin
        rgb_sel |= bus.rgb_req[3*i +: 3];
        pat_sel |= bus.pattern[2*i +: 2];
      end
  end

  always_ff @(posedge clk_1k or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      owner           <= '0;
      hold_cnt        <= '0;
      gap_cnt         <= '0;
      bus.preempt_cnt <= '0;
      bus.grant       <= '0;
      bus.busy        <= 1'b0;
      bus.rgb_out     <= RGB_OFF;
    end else begin
      state           <= state_d;
      owner           <= owner_d;
      hold_cnt        <= hold_d;
      gap_cnt         <= gap_d;
      bus.preempt_cnt <= pre_d;
      bus.grant       <= act_d ? owner_d : '0;
      bus.busy        <= (state_d != ST_IDLE);
      bus.rgb_out     <= act_d ? rgb_sel : RGB_OFF;
    end
  end

  alert_tone_gen #(
    .SLOW_ON_MS   (SLOW_ON_MS),
    .FAST_HALF_MS (FAST_HALF_MS)
  ) u_tone (
    .clk_1k    (clk_1k),
    .rst_n     (rst_n),
    .active    (act_d),
    .pat       (pat_sel),
    .mute      (bus.mute),
    .piezo_out (bus.piezo_out)
  );

endmodule

// File: tb/tb_alert_arbiter.sv
// Directed self-checking bench for alert_arbiter.
// Linear stimulus; expected values worked out by hand per step.
module tb_alert_arbiter;
  import alert_pkg::*;

  logic clk_1k;
  logic rst_n;
  int   total;
  int   bad;
  int   on_ones;
  int   off_ones;

  alert_if #(.N_REQ(4)) bus ();

  alert_arbiter dut (
    .clk_1k (clk_1k),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk_1k = 1'b0;
  always #5 clk_1k = ~clk_1k;

  task automatic step(input int n);
    repeat (n) @(posedge clk_1k);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.mute    = 1'b0;
    bus.req     = 4'b0000;
    bus.pattern = 8'h00;
    bus.rgb_req = {RGB_RED, 3'b000, 3'b000, RGB_GREEN};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_piezo", 32'(bus.piezo_out), 0);
    chk("rst_rgb", 32'(bus.rgb_out), 0);
    chk("rst_pre", 32'(bus.preempt_cnt), 0);
    step(2);
    rst_n = 1'b1;

    // 1: continuous tone, release after 300 cycles
    bus.req = 4'b0001;
    step(1);
    chk("t1_grant", 32'(bus.grant), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_rgb", 32'(bus.rgb_out), 2);
    chk("t1_pz0", 32'(bus.piezo_out), 1);
    step(1);
    chk("t1_pz1", 32'(bus.piezo_out), 0);
    step(1);
    chk("t1_pz2", 32'(bus.piezo_out), 1);
    step(297);
    chk("t1_g299", 32'(bus.grant), 1);
    bus.req = 4'b0000;
    step(1);
    chk("t1_g300", 32'(bus.grant), 0);
    chk("t1_b300", 32'(bus.busy), 1);
    chk("t1_pz300", 32'(bus.piezo_out), 0);
    chk("t1_rgb300", 32'(bus.rgb_out), 0);
    step(49);
    chk("t1_b349", 32'(bus.busy), 1);
    step(1);
    chk("t1_b350", 32'(bus.busy), 0);

    // 2: one-cycle pulse gives exactly MIN_HOLD cycles
    bus.req = 4'b0001;
    step(1);
    chk("t2_g0", 32'(bus.grant), 1);
    bus.req = 4'b0000;
    step(199);
    chk("t2_g199", 32'(bus.grant), 1);
    step(1);
    chk("t2_g200", 32'(bus.grant), 0);
    chk("t2_b200", 32'(bus.busy), 1);
    step(49);
    chk("t2_b249", 32'(bus.busy), 1);
    step(1);
    chk("t2_b250", 32'(bus.busy), 0);

    // 3: preemption after hold met
    bus.req = 4'b0001;
    step(1);
    chk("t3_g0", 32'(bus.grant), 1);
    step(299);
    chk("t3_g299", 32'(bus.grant), 1);
    bus.req = 4'b1001;
    step(1);
    chk("t3_g300", 32'(bus.grant), 0);
    chk("t3_pre", 32'(bus.preempt_cnt), 1);
    step(49);
    chk("t3_g349", 32'(bus.grant), 0);
    step(1);
    chk("t3_g350", 32'(bus.grant), 8);
    chk("t3_rgb", 32'(bus.rgb_out), 4);
    bus.req = 4'b0000;
    step(199);
    chk("t3_g549", 32'(bus.grant), 8);
    step(1);
    chk("t3_g550", 32'(bus.grant), 0);
    chk("t3_pre2", 32'(bus.preempt_cnt), 1);
    step(50);
    chk("t3_idle", 32'(bus.busy), 0);

    // 4: early higher request waits for hold; lower ignored
    bus.req = 4'b0001;
    step(1);
    step(49);
    bus.req = 4'b1011;
    step(51);
    chk("t4_g100", 32'(bus.grant), 1);
    step(99);
    chk("t4_g199", 32'(bus.grant), 1);
    step(1);
    chk("t4_g200", 32'(bus.grant), 0);
    chk("t4_pre", 32'(bus.preempt_cnt), 2);
    step(50);
    chk("t4_g250", 32'(bus.grant), 8);
    bus.req = 4'b0010;
    step(199);
    chk("t4_g449", 32'(bus.grant), 8);
    step(1);
    chk("t4_g450", 32'(bus.grant), 0);
    step(50);
    chk("t4_g500", 32'(bus.grant), 2);
    bus.req = 4'b0000;
    step(250);
    chk("t4_idle", 32'(bus.busy), 0);

    // 5: slow pattern, mute, fast pattern, LED-only
    bus.pattern = 8'b00_00_00_01;
    bus.rgb_req = {RGB_RED, 3'b000, 3'b000, 3'b101};
    bus.req = 4'b0001;
    step(1);
    chk("t5_pz0", 32'(bus.piezo_out), 1);
    chk("t5_rgb", 32'(bus.rgb_out), 5);
    on_ones  = 0;
    off_ones = 0;
    for (int k = 1; k < 1000; k++) begin
      step(1);
      if (bus.piezo_out === 1'b1) begin
        if (k < 500) on_ones++;
        else off_ones++;
      end
    end
    chk("t5_on_ones", 32'(on_ones), 249);
    chk("t5_off_ones", 32'(off_ones), 0);
    step(1);
    chk("t5_pz1000", 32'(bus.piezo_out), 1);
    bus.mute = 1'b1;
    step(1);
    chk("t5_mute_pz", 32'(bus.piezo_out), 0);
    chk("t5_mute_g", 32'(bus.grant), 1);
    chk("t5_mute_rgb", 32'(bus.rgb_out), 5);
    bus.mute = 1'b0;
    step(1);
    chk("t5_unmute", 32'(bus.piezo_out), 1);
    bus.pattern = 8'b00_00_00_10;
    step(1);
    chk("t5_fast_on", 32'(bus.piezo_out), 0);
    step(97);
    chk("t5_fast100", 32'(bus.piezo_out), 0);
    step(99);
    chk("t5_fast199", 32'(bus.piezo_out), 0);
    step(1);
    chk("t5_fast200", 32'(bus.piezo_out), 1);
    bus.pattern = 8'b00_00_00_11;
    step(1);
    chk("t5_led_pz", 32'(bus.piezo_out), 0);
    chk("t5_led_rgb", 32'(bus.rgb_out), 5);
    chk("t5_led_g", 32'(bus.grant), 1);

    // 6: asynchronous reset mid-grant
    rst_n = 1'b0;
    #1;
    chk("t6_grant", 32'(bus.grant), 0);
    chk("t6_rgb", 32'(bus.rgb_out), 0);
    chk("t6_piezo", 32'(bus.piezo_out), 0);
    chk("t6_pre", 32'(bus.preempt_cnt), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    #2 rst_n = 1'b1;
    step(1);
    chk("t6_regrant", 32'(bus.grant), 1);
    chk("t6_rergb", 32'(bus.rgb_out), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
